// File: rtl/tick_countdown_if.sv
// Control/status bundle for tick_countdown: the controller drives the strobes and settings,
// the counter returns its registered status.
interface tick_countdown_if #(
    parameter int PRESCALE_W = 16
);
    // load is a single-cycle strobe; there is no ready.
    // The counter accepts a load on every rising edge outside reset.
    logic                  enable;
    logic                  load;
    logic [2:0]            load_value;
    logic                  auto_reload;
    logic [PRESCALE_W-1:0] prescale;
    logic [2:0]            count;
    logic                  tick;
    logic                  done;
    logic                  busy;
    logic                  dbg_state;

    modport master (
        output enable, load, load_value, auto_reload, prescale,
        input  count, tick, done, busy, dbg_state
    );

    modport slave (
        input  enable, load, load_value, auto_reload, prescale,
        output count, tick, done, busy, dbg_state
    );
endinterface

// File: rtl/tick_countdown.sv
// Prescaled countdown timer: a prescaler divides enabled cycles into ticks,
// each tick steps a 0..4 countdown, and expiry either reloads the count or stops.
module tick_countdown #(
    parameter int PRESCALE_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    tick_countdown_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            count_q, count_d;
    logic [2:0]            reload_q, reload_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic                  tick_q, tick_d;
    logic                  done_q, done_d;

    logic [2:0]            load_clamped;
    logic                  wrap;

    // Values 5..7 saturate so the count can never leave 0..4.
    always_comb begin
        load_clamped = bus.load_value;
        if (bus.load_value > 3'd4) begin
            load_clamped = 3'd4;
        end
    end

    // Equality compare: lowering prescale below pcnt lets pcnt run on through its wrap.
    assign wrap = (pcnt_q == bus.prescale);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        pcnt_d   = pcnt_q;
        tick_d   = 1'b0;
        done_d   = 1'b0;

        if (bus.load) begin
            reload_d = load_clamped;
            count_d  = load_clamped;
            pcnt_d   = '0;
            state_d  = RUN;
        end else if ((state_q == RUN) && bus.enable) begin
            if (!wrap) begin
                pcnt_d = pcnt_q + 1'b1;
            end else begin
                pcnt_d = '0;
                tick_d = 1'b1;
                if (count_q != 3'd0) begin
                    count_d = count_q - 3'd1;
                end else begin
                    done_d = 1'b1;
                    if (bus.auto_reload) begin
                        count_d = reload_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= 3'd0;
            reload_q <= 3'd0;
            pcnt_q   <= '0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            pcnt_q   <= pcnt_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
        end
    end

    assign bus.count     = count_q;
    assign bus.tick      = tick_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_tick_countdown.sv
// Directed bench for tick_countdown: each task drives one scenario and checks
// {count, tick, done, busy} against hand-derived values after every edge.
module tb_tick_countdown;

    localparam int PW = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [5:0] obs;
    logic [5:0] exp_v;
    logic [2:0] ec;

    tick_countdown_if #(.PRESCALE_W(PW)) bus_if ();

    tick_countdown #(.PRESCALE_W(PW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clock = ~clock;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [2:0] lv, input logic [PW-1:0] ps, input logic ar);
        bus_if.load        = 1'b1;
        bus_if.load_value  = lv;
        bus_if.prescale    = ps;
        bus_if.auto_reload = ar;
        step();
        bus_if.load        = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus_if.load       = 1'b1;
        bus_if.load_value = 3'd3;
        step();
        step();
        obs = {bus_if.count, bus_if.tick, bus_if.done, bus_if.busy};
        n_checks++;
        if (obs !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_hold: got cnt/tick/done/busy=%b want %b", obs, 6'b000000);
        end
        bus_if.load = 1'b0;
        #3 reset = 1'b0;
        step();
        obs = {bus_if.count, bus_if.tick, bus_if.done, bus_if.busy};
        n_checks++;
        if (obs !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b want %b", obs, 6'b000000);
        end
    endtask

    task automatic test_basic();
        do_load(3'd3, 4'd2, 1'b0);
        obs = {bus_if.count, bus_if.tick, bus_if.done, bus_if.busy};
        n_checks++;
        if (obs !== 6'b011001) begin
            n_fail++;
            $display("FAIL basic_after_load: got %b want %b", obs, 6'b011001);
        end
        for (int k = 1; k <= 14; k++) begin
            step();
            ec = (k < 12) ? 3'(3 - k / 3) : 3'd0;
            exp_v = {ec, (k <= 12) && (k % 3 == 0), k == 12, k < 12};
            obs = {bus_if.count, bus_if.tick, bus_if.done, bus_if.busy};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL basic k=%0d: got %b want %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_auto_reload();
        do_load(3'd4, 4'd0, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            if (k == 16) bus_if.auto_reload = 1'b0;
            step();
            ec = (k == 20) ? 3'd0 : 3'(4 - k % 5);
            exp_v = {ec, 1'b1, k % 5 == 0, k < 20};
            obs = {bus_if.count, bus_if.tick, bus_if.done, bus_if.busy};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL auto_reload k=%0d: got %b want %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_clamp_zero();
        do_load(3'd7, 4'd5, 1'b0);
        obs = {bus_if.count, bus_if.tick, bus_if.done, bus_if.busy};
        n_checks++;
        if (obs !== 6'b100001) begin
            n_fail++;
            $display("FAIL clamp7: got %b want %b", obs, 6'b100001);
        end
        do_load(3'd0, 4'd0, 1'b0);
        obs = {bus_if.count, bus_if.tick, bus_if.done, bus_if.busy};
        n_checks++;
        if (obs !== 6'b000001) begin
            n_fail++;
            $display("FAIL zero_load: got %b want %b", obs, 6'b000001);
        end
        step();
        obs = {bus_if.count, bus_if.tick, bus_if.done, bus_if.busy};
        n_checks++;
        if (obs !== 6'b000110) begin
            n_fail++;
            $display("FAIL zero_expiry: got %b want %b", obs, 6'b000110);
        end
        step();
        obs = {bus_if.count, bus_if.tick, bus_if.done, bus_if.busy};
        n_checks++;
        if (obs !== 6'b000000) begin
            n_fail++;
            $display("FAIL zero_after: got %b want %b", obs, 6'b000000);
        end
        // Clamped 5 must also be what auto-reload restores.
        do_load(3'd5, 4'd0, 1'b1);
        repeat (5) step();
        obs = {bus_if.count, bus_if.tick, bus_if.done, bus_if.busy};
        n_checks++;
        if (obs !== 6'b100111) begin
            n_fail++;
            $display("FAIL clamp5_reload: got %b want %b", obs, 6'b100111);
        end
    endtask

    task automatic test_enable_gating();
        do_load(3'd3, 4'd2, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step();
            ec = (k < 3) ? 3'd3 : 3'd2;
            exp_v = {ec, k == 3, 1'b0, 1'b1};
            obs = {bus_if.count, bus_if.tick, bus_if.done, bus_if.busy};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL gate_pre k=%0d: got %b want %b", k, obs, exp_v);
            end
        end
        bus_if.enable = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            obs = {bus_if.count, bus_if.tick, bus_if.done, bus_if.busy};
            n_checks++;
            if (obs !== 6'b010001) begin
                n_fail++;
                $display("FAIL gate_frozen k=%0d: got %b want %b", k, obs, 6'b010001);
            end
        end
        bus_if.enable = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            step();
            ec = (j < 2) ? 3'd2 : (j < 5) ? 3'd1 : 3'd0;
            exp_v = {ec, j % 3 == 2, j == 8, j < 8};
            obs = {bus_if.count, bus_if.tick, bus_if.done, bus_if.busy};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL gate_resume j=%0d: got %b want %b", j, obs, exp_v);
            end
        end
    endtask

    task automatic test_collision();
        do_load(3'd1, 4'd1, 1'b0);
        repeat (3) step();
        obs = {bus_if.count, bus_if.tick, bus_if.done, bus_if.busy};
        n_checks++;
        if (obs !== 6'b000001) begin
            n_fail++;
            $display("FAIL collide_pre: got %b want %b", obs, 6'b000001);
        end
        do_load(3'd2, 4'd1, 1'b0);
        obs = {bus_if.count, bus_if.tick, bus_if.done, bus_if.busy};
        n_checks++;
        if (obs !== 6'b010001) begin
            n_fail++;
            $display("FAIL collide_edge: got %b want %b", obs, 6'b010001);
        end
        step();
        obs = {bus_if.count, bus_if.tick, bus_if.done, bus_if.busy};
        n_checks++;
        if (obs !== 6'b010001) begin
            n_fail++;
            $display("FAIL collide_pcnt0: got %b want %b", obs, 6'b010001);
        end
        step();
        obs = {bus_if.count, bus_if.tick, bus_if.done, bus_if.busy};
        n_checks++;
        if (obs !== 6'b001101) begin
            n_fail++;
            $display("FAIL collide_tick: got %b want %b", obs, 6'b001101);
        end
    endtask

    task automatic test_async_reset();
        do_load(3'd3, 4'd2, 1'b0);
        step();
        #3 reset = 1'b1;
        #1;
        obs = {bus_if.count, bus_if.tick, bus_if.done, bus_if.busy};
        n_checks++;
        if (obs !== 6'b000000) begin
            n_fail++;
            $display("FAIL async_reset_now: got %b want %b", obs, 6'b000000);
        end
        bus_if.load       = 1'b1;
        bus_if.load_value = 3'd2;
        step();
        obs = {bus_if.count, bus_if.tick, bus_if.done, bus_if.busy};
        n_checks++;
        if (obs !== 6'b000000) begin
            n_fail++;
            $display("FAIL load_in_reset: got %b want %b", obs, 6'b000000);
        end
        bus_if.load = 1'b0;
        #3 reset = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            step();
            obs = {bus_if.count, bus_if.tick, bus_if.done, bus_if.busy};
            n_checks++;
            if (obs !== 6'b000000) begin
                n_fail++;
                $display("FAIL post_reset k=%0d: got %b want %b", k, obs, 6'b000000);
            end
        end
        reset = 1'b1;
        bus_if.load       = 1'b1;
        bus_if.load_value = 3'd1;
        #3 reset = 1'b0;
        step();
        bus_if.load = 1'b0;
        obs = {bus_if.count, bus_if.tick, bus_if.done, bus_if.busy};
        n_checks++;
        if (obs !== 6'b001001) begin
            n_fail++;
            $display("FAIL first_load_after_reset: got %b want %b", obs, 6'b001001);
        end
    endtask

    task automatic test_prescale_change();
        do_load(3'd0, 4'd5, 1'b0);
        repeat (4) step();
        bus_if.prescale = 4'd2;
        for (int j = 1; j <= 15; j++) begin
            step();
            exp_v = {3'd0, j == 15, j == 15, j < 15};
            obs = {bus_if.count, bus_if.tick, bus_if.done, bus_if.busy};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL prescale_lower j=%0d: got %b want %b", j, obs, exp_v);
            end
        end
    endtask

    initial begin
        bus_if.enable      = 1'b1;
        bus_if.load        = 1'b0;
        bus_if.load_value  = 3'd0;
        bus_if.auto_reload = 1'b0;
        bus_if.prescale    = '0;
        test_reset();
        test_basic();
        test_auto_reload();
        test_clamp_zero();
        test_enable_gating();
        test_collision();
        test_async_reset();
        test_prescale_change();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tick_countdown.md
TICK_COUNTDOWN -- requirements
Module: tick_countdown

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 16, width of prescale input and internal prescale counter.
REQ-002 SHALL have port clock  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  advance permit; low freezes prescaler and count.
REQ-005 SHALL have port load  input  1  single-cycle strobe; start/restart a countdown.
REQ-006 SHALL have port load_value  input  3  countdown start value, legal range 0..4.
REQ-007 SHALL have port auto_reload  input  1  1 = restart from stored value on expiry; 0 = stop.
REQ-008 SHALL have port prescale  input  PRESCALE_W  tick period minus one, in enabled clock cycles.
REQ-009 SHALL have port count  output  3  current countdown value, registered.
REQ-010 SHALL have port tick  output  1  one-cycle pulse per prescaler wrap, registered.
REQ-011 SHALL have port done  output  1  one-cycle pulse on countdown expiry, registered.
REQ-012 SHALL have port busy  output  1  high while in RUN state, registered.

Function
REQ-013 SHALL implement two states: IDLE (busy=0) and RUN (busy=1).
REQ-014 SHALL hold an internal reload register (3 bits) and prescale counter pcnt (PRESCALE_W bits).
REQ-015 SHALL, on load=1 in any state: reload<=clamp(load_value), count<=clamp(load_value), pcnt<=0, state<=RUN; clamp maps 5..7 to 4.
REQ-016 SHALL give load priority over enable, tick and expiry in the same cycle; tick and done SHALL be 0 in the cycle following a load edge.
REQ-017 SHALL, in RUN with enable=1 and pcnt!=prescale: pcnt<=pcnt+1; tick<=0.
REQ-018 SHALL, in RUN with enable=1 and pcnt==prescale: pcnt<=0, tick<=1 for exactly one cycle.
REQ-019 SHALL, on a tick edge with count>0: count<=count-1, done<=0.
REQ-020 SHALL, on a tick edge with count==0: done<=1 for one cycle; if auto_reload=1, count<=reload and stay RUN; else stay count=0, go IDLE.
REQ-021 SHALL sample auto_reload only at the expiry edge.
REQ-022 SHALL yield period (N+1)*(prescale+1) enabled cycles from load to done, N=clamped load_value.
REQ-023 SHALL, with enable=0, hold pcnt, count, state; tick and done SHALL be 0.
REQ-024 SHALL, in IDLE, hold count and pcnt, keep tick=0, done=0, ignore enable.
REQ-025 SHALL treat prescale=0 as a tick on every enabled RUN cycle.
REQ-026 SHALL sample prescale every cycle; a change below current pcnt SHALL NOT wrap pcnt; compare uses equality, so pcnt continues to all-ones wrap then 0 before matching.
REQ-027 SHALL never present count outside 0..4.

Reset
REQ-028 SHALL, while reset=1 (asynchronously, independent of clock): state=IDLE, count=0, reload=0, pcnt=0, tick=0, done=0, busy=0.
REQ-029 SHALL abort any countdown in progress on reset; no done pulse SHALL be generated by reset or its release.
REQ-030 SHALL ignore load while reset=1; first load honoured on first rising edge after release.

Verification
REQ-031 Basic: prescale=2, load_value=3, auto_reload=0, enable=1 -> tick every 3 cycles; count 3,2,1,0; done single pulse 12 cycles after load edge; busy falls same edge.
REQ-032 Auto-reload: prescale=0, load_value=4, auto_reload=1 -> count 4,3,2,1,0,4,...; done every 5 cycles; busy stays 1.
REQ-033 Clamp/zero: load_value=7 -> count=4; load_value=0, prescale=0 -> done on first enabled edge after load.
REQ-034 Enable gating: drop enable for 10 cycles mid-count at count=2 -> count, pcnt frozen, no tick/done; resumes exact remaining period.
REQ-035 Collision: load asserted on the same edge as an expiry tick -> count=new value, done=0, tick=0, pcnt=0.
REQ-036 Async reset mid-run (between clock edges, count=3) -> all outputs 0 immediately; no done after release.
